// File: rtl/deflate_bit_packer_if.sv
// Handshake bundle between the Huffman code-word producers, the bit packer
// and the downstream byte sink.
interface deflate_bit_packer_if #(
  parameter int IN_WIDTH  = 18,
  parameter int LEN_WIDTH = 5,
  parameter int CNT_WIDTH = 32
);
  logic                 code_valid_in;
  logic                 code_ready_out;
  logic [IN_WIDTH-1:0]  code_data_in;
  logic [LEN_WIDTH-1:0] code_len_in;
  logic                 flush_in;
  logic                 out_valid;
  logic                 out_ready;
  logic [7:0]           out_data;
  logic                 flush_done_out;
  logic [CNT_WIDTH-1:0] total_bytes_out;

  modport master (
    output code_valid_in, code_data_in, code_len_in, flush_in, out_ready,
    input  code_ready_out, out_valid, out_data, flush_done_out, total_bytes_out
  );

  modport slave (
    input  code_valid_in, code_data_in, code_len_in, flush_in, out_ready,
    output code_ready_out, out_valid, out_data, flush_done_out, total_bytes_out
  );
endinterface

// File: rtl/deflate_bit_packer.sv
// DEFLATE bit packer: concatenates LSB-first variable-length code words into
// a byte stream, with an end-of-block flush that zero-pads the last byte.
module deflate_bit_packer #(
  parameter int IN_WIDTH  = 18,
  parameter int LEN_WIDTH = 5,
  parameter int ACC_WIDTH = 32,
  parameter int CNT_WIDTH = 32
) (
  input logic                 clk,
  input logic                 rst,
  deflate_bit_packer_if.slave bus
);
  localparam int BCW = $clog2(ACC_WIDTH + 1);
  localparam logic [BCW-1:0] READY_MAX = BCW'(ACC_WIDTH - IN_WIDTH);
  localparam logic [BCW-1:0] BYTE_BITS = BCW'(8);

  typedef enum logic [1:0] {RUN, FLUSH, DONE} state_t;

  // Lengths above the widest code word saturate to it.
  function automatic logic [LEN_WIDTH-1:0] sat_len(input logic [LEN_WIDTH-1:0] len);
    if (len > LEN_WIDTH'(IN_WIDTH)) return LEN_WIDTH'(IN_WIDTH);
    return len;
  endfunction

  function automatic logic [ACC_WIDTH-1:0] mask_code(input logic [IN_WIDTH-1:0]  data,
                                                     input logic [LEN_WIDTH-1:0] len);
    logic [ACC_WIDTH-1:0] keep;
    keep = (ACC_WIDTH'(1) << len) - ACC_WIDTH'(1);
    return ACC_WIDTH'(data) & keep;
  endfunction

  state_t               state;
  logic [ACC_WIDTH-1:0] acc;
  logic [BCW-1:0]       bit_cnt;
  logic                 out_valid_r;
  logic [7:0]           out_data_r;
  logic                 flush_done_r;
  logic [CNT_WIDTH-1:0] total_r;

  logic                 code_ready;
  logic                 out_free;
  logic                 extract;
  logic                 pad;
  logic                 accept;
  logic [LEN_WIDTH-1:0] len_sat;
  logic [ACC_WIDTH-1:0] acc_shift;
  logic [BCW-1:0]       cnt_shift;
  logic [ACC_WIDTH-1:0] acc_next;
  logic [BCW-1:0]       cnt_next;

  assign code_ready          = (state == RUN) && (bit_cnt <= READY_MAX);
  assign bus.code_ready_out  = code_ready;
  assign bus.out_valid       = out_valid_r;
  assign bus.out_data        = out_data_r;
  assign bus.flush_done_out  = flush_done_r;
  assign bus.total_bytes_out = total_r;

  // Extraction happens before insertion, so a new code lands at the
  // post-extraction bit count.
  always_comb begin
    out_free  = !out_valid_r || bus.out_ready;
    extract   = out_free && (bit_cnt >= BYTE_BITS);
    pad       = out_free && (state == FLUSH) && (bit_cnt != '0) && (bit_cnt < BYTE_BITS);
    accept    = bus.code_valid_in && code_ready;
    len_sat   = sat_len(bus.code_len_in);
    acc_shift = acc;
    cnt_shift = bit_cnt;
    if (extract) begin
      acc_shift = acc >> 8;
      cnt_shift = bit_cnt - BYTE_BITS;
    end else if (pad) begin
      acc_shift = '0;
      cnt_shift = '0;
    end
    acc_next = acc_shift;
    cnt_next = cnt_shift;
    if (accept) begin
      acc_next = acc_shift | (mask_code(bus.code_data_in, len_sat) << cnt_shift);
      cnt_next = cnt_shift + BCW'(len_sat);
    end
  end

  // Bits above bit_cnt are always zero, so a padded byte is just acc[7:0].
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= RUN;
      acc          <= '0;
      bit_cnt      <= '0;
      out_valid_r  <= 1'b0;
      out_data_r   <= '0;
      flush_done_r <= 1'b0;
      total_r      <= '0;
    end else begin
      acc     <= acc_next;
      bit_cnt <= cnt_next;
      if (extract || pad) begin
        out_data_r  <= acc[7:0];
        out_valid_r <= 1'b1;
      end else if (bus.out_ready) begin
        out_valid_r <= 1'b0;
      end
      if (out_valid_r && bus.out_ready) total_r <= total_r + CNT_WIDTH'(1);
      flush_done_r <= 1'b0;
      case (state)
        RUN:   if (bus.flush_in) state <= FLUSH;
        FLUSH: if ((bit_cnt == '0) && out_free) begin
                 state        <= DONE;
                 flush_done_r <= 1'b1;
               end
        DONE:  state <= RUN;
        default: state <= RUN;
      endcase
    end
  end
endmodule

// File: tb/tb_deflate_bit_packer.sv
// Randomised and directed bench for deflate_bit_packer against a bit-queue
// reference model of the packed stream.
module tb_deflate_bit_packer;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  deflate_bit_packer_if #(.IN_WIDTH(18), .LEN_WIDTH(5), .CNT_WIDTH(32)) bus ();

  deflate_bit_packer #(.IN_WIDTH(18), .LEN_WIDTH(5), .ACC_WIDTH(32), .CNT_WIDTH(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int total = 0;
  int bad   = 0;
  int n_acc = 0;
  int n_done = 0;
  logic [7:0] got[$];

  // reference model: pending stream bits plus the output byte register
  bit          mq[$];
  int          m_state;   // 0 run, 1 flush, 2 done
  bit          m_ov;
  logic [7:0]  m_od;
  bit          m_done;
  int unsigned m_total;

  function automatic bit m_ready();
    return (m_state == 0) && (mq.size() <= 14);
  endfunction

  task automatic tick();
    bit rdy, fr;
    int qs0, l;
    logic [7:0] b;
    rdy = m_ready();
    total++;
    if (bus.out_valid !== m_ov) begin
      bad++; $display("FAIL out_valid @%0t: got %0b expected %0b", $time, bus.out_valid, m_ov);
    end
    if (m_ov) begin
      total++;
      if (bus.out_data !== m_od) begin
        bad++; $display("FAIL out_data @%0t: got %0h expected %0h", $time, bus.out_data, m_od);
      end
    end
    total++;
    if (bus.code_ready_out !== rdy) begin
      bad++; $display("FAIL code_ready @%0t: got %0b expected %0b", $time, bus.code_ready_out, rdy);
    end
    total++;
    if (bus.flush_done_out !== m_done) begin
      bad++; $display("FAIL flush_done @%0t: got %0b expected %0b", $time, bus.flush_done_out, m_done);
    end
    total++;
    if (bus.total_bytes_out !== m_total) begin
      bad++; $display("FAIL total_bytes @%0t: got %0d expected %0d", $time, bus.total_bytes_out, m_total);
    end
    if (bus.code_valid_in && rdy) n_acc++;
    if (bus.flush_done_out === 1'b1) n_done++;
    if (bus.out_valid === 1'b1 && bus.out_ready) got.push_back(bus.out_data);
    if (rst) begin
      mq.delete(); m_state = 0; m_ov = 0; m_od = 0; m_done = 0; m_total = 0;
    end else begin
      fr  = !m_ov || bus.out_ready;
      qs0 = mq.size();
      if (m_ov && bus.out_ready) m_total++;
      if (fr) m_ov = 0;
      if (fr && (qs0 >= 8 || (m_state == 1 && qs0 > 0))) begin
        b = 8'h00;
        for (int i = 0; i < 8; i++) if (mq.size() > 0) b[i] = mq.pop_front();
        m_od = b; m_ov = 1;
      end
      if (bus.code_valid_in && rdy) begin
        l = (bus.code_len_in > 18) ? 18 : int'(bus.code_len_in);
        for (int i = 0; i < l; i++) mq.push_back(bus.code_data_in[i]);
      end
      m_done = 0;
      case (m_state)
        0: if (bus.flush_in) m_state = 1;
        1: if (qs0 == 0 && fr) begin m_state = 2; m_done = 1; end
        default: m_state = 0;
      endcase
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    bus.code_valid_in = 0; bus.flush_in = 0; bus.out_ready = 1;
    rst = 1; tick(); tick(); rst = 0;
    got.delete(); n_done = 0;
  endtask

  task automatic send(input int len, input logic [17:0] data);
    int a0;
    bit ok;
    a0 = n_acc; ok = 0;
    bus.code_valid_in = 1; bus.code_len_in = 5'(len); bus.code_data_in = data;
    for (int i = 0; i < 50; i++) begin
      tick();
      if (n_acc > a0) begin ok = 1; break; end
    end
    bus.code_valid_in = 0;
    total++;
    if (!ok) begin bad++; $display("FAIL send_timeout: got none expected accept len=%0d", len); end
  endtask

  task automatic do_flush();
    bus.flush_in = 1; tick(); bus.flush_in = 0;
  endtask

  task automatic wait_done();
    bit seen;
    seen = 0;
    for (int i = 0; i < 60; i++) begin
      if (bus.flush_done_out === 1'b1) seen = 1;
      tick();
      if (seen) break;
    end
    tick(); tick();
    total++;
    if (!seen) begin bad++; $display("FAIL flush_done_timeout: got 0 expected 1"); end
  endtask

  task automatic test_reset();
    total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL rst_out_valid: got %0b expected 0", bus.out_valid); end
    total++; if (bus.out_data !== 8'h00) begin bad++; $display("FAIL rst_out_data: got %0h expected 0", bus.out_data); end
    total++; if (bus.flush_done_out !== 1'b0) begin bad++; $display("FAIL rst_flush_done: got %0b expected 0", bus.flush_done_out); end
    total++; if (bus.total_bytes_out !== 32'd0) begin bad++; $display("FAIL rst_total: got %0d expected 0", bus.total_bytes_out); end
    total++; if (bus.code_ready_out !== 1'b1) begin bad++; $display("FAIL rst_ready: got %0b expected 1", bus.code_ready_out); end
    rst = 0;
  endtask

  task automatic test_back_to_back();
    do_reset();
    bus.code_valid_in = 1; bus.code_len_in = 5'd5; bus.code_data_in = 18'h16; tick();
    bus.code_len_in = 5'd6; bus.code_data_in = 18'h04; tick();
    bus.code_valid_in = 0;
    do_flush();
    wait_done();
    total++; if (got.size() != 2) begin bad++; $display("FAIL b2b_count: got %0d expected 2", got.size()); end
    else begin
      total++; if (got[0] !== 8'h96) begin bad++; $display("FAIL b2b_byte0: got %0h expected 96", got[0]); end
      total++; if (got[1] !== 8'h00) begin bad++; $display("FAIL b2b_byte1: got %0h expected 00", got[1]); end
    end
    total++; if (n_done != 1) begin bad++; $display("FAIL b2b_done_pulses: got %0d expected 1", n_done); end
    total++; if (bus.total_bytes_out !== 32'd2) begin bad++; $display("FAIL b2b_total: got %0d expected 2", bus.total_bytes_out); end
  endtask

  task automatic test_backpressure();
    int a0;
    bit rdy_back;
    do_reset();
    bus.out_ready = 0;
    a0 = n_acc;
    bus.code_valid_in = 1; bus.code_len_in = 5'd18; bus.code_data_in = 18'h3FFFF;
    repeat (8) tick();
    bus.code_valid_in = 0;
    total++; if (n_acc - a0 != 2) begin bad++; $display("FAIL bp_accepts: got %0d expected 2", n_acc - a0); end
    total++; if (bus.out_data !== 8'hFF) begin bad++; $display("FAIL bp_hold_data: got %0h expected ff", bus.out_data); end
    total++; if (bus.code_ready_out !== 1'b0) begin bad++; $display("FAIL bp_ready_low: got %0b expected 0", bus.code_ready_out); end
    bus.out_ready = 1;
    rdy_back = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (bus.code_ready_out === 1'b1) begin rdy_back = 1; break; end
    end
    total++; if (!rdy_back) begin bad++; $display("FAIL bp_ready_back: got 0 expected 1"); end
    do_flush();
    wait_done();
    total++; if (got.size() != 5) begin bad++; $display("FAIL bp_count: got %0d expected 5", got.size()); end
    else begin
      for (int i = 0; i < 4; i++) begin
        total++; if (got[i] !== 8'hFF) begin bad++; $display("FAIL bp_byte%0d: got %0h expected ff", i, got[i]); end
      end
      total++; if (got[4] !== 8'h0F) begin bad++; $display("FAIL bp_tail: got %0h expected 0f", got[4]); end
    end
  endtask

  task automatic test_mask_zero();
    do_reset();
    send(0, 18'h3FFFF);
    send(3, 18'h3FFFF);
    do_flush();
    wait_done();
    total++; if (got.size() != 1) begin bad++; $display("FAIL mask_count: got %0d expected 1", got.size()); end
    else begin
      total++; if (got[0] !== 8'h07) begin bad++; $display("FAIL mask_byte: got %0h expected 07", got[0]); end
    end
  endtask

  task automatic test_empty_flush();
    do_reset();
    do_flush();
    total++; if (bus.code_ready_out !== 1'b0) begin bad++; $display("FAIL ef_ready_flush: got %0b expected 0", bus.code_ready_out); end
    tick();
    total++; if (bus.flush_done_out !== 1'b1) begin bad++; $display("FAIL ef_done: got %0b expected 1", bus.flush_done_out); end
    total++; if (bus.code_ready_out !== 1'b0) begin bad++; $display("FAIL ef_ready_done: got %0b expected 0", bus.code_ready_out); end
    tick();
    total++; if (bus.flush_done_out !== 1'b0) begin bad++; $display("FAIL ef_done_once: got %0b expected 0", bus.flush_done_out); end
    total++; if (got.size() != 0) begin bad++; $display("FAIL ef_no_byte: got %0d expected 0", got.size()); end
  endtask

  task automatic test_simultaneous();
    do_reset();
    bus.code_valid_in = 1; bus.code_len_in = 5'd4; bus.code_data_in = 18'hA; bus.flush_in = 1;
    tick();
    bus.code_valid_in = 0; bus.flush_in = 0;
    wait_done();
    total++; if (got.size() != 1) begin bad++; $display("FAIL sim_count: got %0d expected 1", got.size()); end
    else begin
      total++; if (got[0] !== 8'h0A) begin bad++; $display("FAIL sim_byte: got %0h expected 0a", got[0]); end
    end
    total++; if (n_done != 1) begin bad++; $display("FAIL sim_done_pulses: got %0d expected 1", n_done); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    bus.out_ready = 0;
    bus.code_valid_in = 1; bus.code_len_in = 5'd12; bus.code_data_in = 18'hABC; tick();
    bus.code_len_in = 5'd8; bus.code_data_in = 18'h33; tick();
    bus.code_valid_in = 0;
    total++; if (bus.out_valid !== 1'b1) begin bad++; $display("FAIL rm_pre_valid: got %0b expected 1", bus.out_valid); end
    rst = 1; tick(); rst = 0;
    total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL rm_valid: got %0b expected 0", bus.out_valid); end
    total++; if (bus.total_bytes_out !== 32'd0) begin bad++; $display("FAIL rm_total: got %0d expected 0", bus.total_bytes_out); end
    bus.out_ready = 1;
    got.delete();
    send(8, 18'h5A);
    do_flush();
    wait_done();
    total++; if (got.size() != 1) begin bad++; $display("FAIL rm_count: got %0d expected 1", got.size()); end
    else begin
      total++; if (got[0] !== 8'h5A) begin bad++; $display("FAIL rm_byte: got %0h expected 5a", got[0]); end
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int i = 0; i < 2000; i++) begin
      bus.code_valid_in = ($urandom_range(0, 3) != 0);
      bus.code_len_in   = 5'($urandom_range(0, 31));
      bus.code_data_in  = 18'($urandom_range(0, 18'h3FFFF));
      bus.out_ready     = ($urandom_range(0, 3) != 0);
      bus.flush_in      = ($urandom_range(0, 39) == 0);
      tick();
    end
    bus.code_valid_in = 0; bus.flush_in = 0; bus.out_ready = 1;
    repeat (4) tick();
    do_flush();
    wait_done();
    total++; if (bus.total_bytes_out !== 32'(got.size())) begin
      bad++; $display("FAIL rnd_total: got %0d expected %0d", bus.total_bytes_out, got.size());
    end
    total++; if (mq.size() != 0) begin bad++; $display("FAIL rnd_drained: got %0d expected 0", mq.size()); end
  endtask

  initial begin
    mq.delete(); m_state = 0; m_ov = 0; m_od = 0; m_done = 0; m_total = 0;
    rst = 1;
    bus.code_valid_in = 0; bus.code_len_in = '0; bus.code_data_in = '0;
    bus.flush_in = 0; bus.out_ready = 1;
    @(posedge clk); @(negedge clk);
    @(posedge clk); @(negedge clk);
    test_reset();
    test_back_to_back();
    test_backpressure();
    test_mask_zero();
    test_empty_flush();
    test_simultaneous();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/deflate_bit_packer.md
Name: deflate_bit_packer

Overview:
- Downstream of the static distance Huffman encoder and the literal/length encoder.
- Accepts variable-length, LSB-first, right-aligned code words of up to 18 bits with a valid-bit count.
- Concatenates them into a continuous DEFLATE bit stream and emits it as bytes over a valid/ready interface.
- Supports an end-of-block flush that zero-pads the final partial byte and signals completion.

Parameters:
- IN_WIDTH, 18, width of code_data_in (max code length in bits)
- LEN_WIDTH, 5, width of code_len_in
- ACC_WIDTH, 32, bit accumulator width
- CNT_WIDTH, 32, width of total_bytes_out

Ports:
- clk  in  1  clock; all logic on rising edge
- rst  in  1  synchronous reset, active-high
- code_valid_in  in  1  code word present
- code_ready_out  out  1  packer can accept a code this cycle
- code_data_in  in  IN_WIDTH  code bits; bit 0 is transmitted first
- code_len_in  in  LEN_WIDTH  number of valid bits, 0..18
- flush_in  in  1  single-cycle end-of-block flush request
- out_valid  out  1  out_data holds a byte
- out_ready  in  1  downstream accepts byte
- out_data  out  8  packed byte; bit 0 is the earliest stream bit
- flush_done_out  out  1  one-cycle pulse when flush is complete
- total_bytes_out  out  CNT_WIDTH  bytes transferred since reset

Behaviour:
- Reset (rst high at a clock edge):
  - Accumulator and bit_cnt cleared; FSM goes to RUN.
  - out_valid=0, out_data=0, flush_done_out=0, total_bytes_out=0.
  - Partial bits are discarded, including when reset arrives mid-flush.
- Input acceptance:
  - code_ready_out = (state==RUN) && (bit_cnt <= ACC_WIDTH-IN_WIDTH, i.e. 14). It is registered-state derived only, with no combinational path from code_len_in.
  - A code is accepted on an edge where code_valid_in && code_ready_out.
  - Bits at positions >= code_len_in are masked to 0.
  - code_len_in values 19..31 are treated as 18.
  - code_len_in=0 is accepted as a no-op.
- Accumulation:
  - The masked code is ORed in at position bit_cnt_after_extract; bit_cnt += len.
  - bit_cnt never exceeds 32.
- Byte extraction:
  - Output register is free when out_valid=0 or out_ready=1.
  - When the register is free and bit_cnt >= 8, acc[7:0] is loaded into out_data, out_valid=1, the accumulator shifts right by 8, and bit_cnt -= 8.
  - Extraction and acceptance may occur in the same cycle. Extraction is applied first; new bits go at (bit_cnt-8).
  - Latency: a code accepted at edge N that completes a byte gives out_valid=1 after edge N+1.
  - Max throughput is 1 byte/cycle.
- Output handshake:
  - out_data is stable while out_valid && !out_ready.
  - out_valid drops when a byte is taken and no new byte is ready.
  - total_bytes_out increments on each out_valid && out_ready and wraps modulo 2^CNT_WIDTH.
- FSM states: RUN, FLUSH, DONE.
  - RUN -> FLUSH when flush_in=1. A code accepted in the same cycle is included before padding.
  - FLUSH: code_ready_out=0. Full bytes are extracted normally. When 0 < bit_cnt < 8 and the output register is free, the partial byte is emitted with zero-padded upper bits and bit_cnt becomes 0.
  - FLUSH -> DONE when bit_cnt==0 and (out_valid==0 or out_ready==1).
  - DONE: flush_done_out=1 for exactly one cycle, then -> RUN.
  - flush_in is ignored outside RUN.
  - Flush with an empty accumulator goes FLUSH -> DONE with no byte emitted.
- Stream alignment: byte alignment restarts after a flush (bit_cnt=0).

Test Plan:
- Two codes back to back: len 5 data 0x16, then len 6 data 0x04; then flush -> bytes 0x96, 0x00. Afterwards flush_done_out pulses once and total_bytes_out=2.
- Backpressure: out_ready=0, continuous len 18 data 0x3FFFF -> exactly 2 codes accepted. out_data=0xFF is held stable and code_ready_out stays 0 (bit_cnt=28). Release out_ready=1 -> bytes 0xFF and ready reasserts when bit_cnt <= 14.
- Masking and zero length: len 0 data 0x3FFFF, then len 3 data 0x3FFFF, then flush -> single byte 0x07.
- Empty flush: flush_in with bit_cnt=0 -> no out_valid; flush_done_out pulses 2 cycles later; code_ready_out=0 during FLUSH and DONE.
- Simultaneous code_valid_in (len 4, data 0xA) and flush_in -> code included; byte 0x0A emitted, then flush_done_out pulses.
- Reset mid-stream: 12 bits buffered and out_valid=1, assert rst -> next cycle out_valid=0, total_bytes_out=0. A following len 8 data 0x5A produces byte 0x5A.
